db_arbiter: RTL and testbench
=============================

# db_arbiter

Round-robin arbiter and access sequencer that shares the single system data bus (one address, one data path, read/write strobes) between up to NUM_REQ masters (CPU, DMA, PPU fetch, debug port). It sits between the masters and the bus-attached memories/peripherals. It serialises all bus traffic into fixed two-cycle transactions, returns read data and a one-cycle ack to the winning master, and never drives the bus when idle.

## Interface
- NUM_REQ, 4: number of requesting masters (2..8).
- ADDR_W, 16: bus address width.
- DATA_W, 8: bus data width.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-master request; held high until that master's ack.
- we  in  NUM_REQ  per-master write (1) / read (0); stable while req high.
- addr  in  NUM_REQ*ADDR_W  per-master address, master i at bits [i*ADDR_W +: ADDR_W].
- wdata  in  NUM_REQ*DATA_W  per-master write data, same packing.
- lock  in  NUM_REQ  per-master bus-lock request (see Configuration).
- gnt  out  NUM_REQ  one-hot current owner; all-zero when idle.
- ack  out  NUM_REQ  one-cycle completion pulse to the owner.
- rdata  out  DATA_W  read data, valid in the ack cycle of a read.
- bus_addr  out  ADDR_W  bus address.
- bus_wdata  out  DATA_W  bus write data.
- bus_oe  out  1  bus write-data drive enable (slaves tristate against this).
- bus_rd  out  1  read strobe.
- bus_wr  out  1  write strobe.
- bus_rdata  in  DATA_W  bus read data returned by the selected slave.

## Operation
- States: IDLE, ACCESS, ACK.
- IDLE: if any req, pick winner by round-robin starting at index ptr+1 (mod NUM_REQ); register gnt, bus_addr, bus_wdata, direction; go ACCESS. Otherwise stay.
- ACCESS: bus_rd = !we_owner or bus_wr/bus_oe = we_owner for exactly this cycle; on the closing edge capture bus_rdata into rdata (reads only; writes leave rdata unchanged); go ACK.
- ACK: ack[owner]=1, strobes low, bus_oe low; ptr <= owner. Arbitrate among req with owner masked (unless lock held, see Configuration): if winner exists, go ACCESS directly with new gnt/addr/data; else gnt <= 0, go IDLE.
- Round-robin: with ptr=p, priority order p+1, p+2, ..., p (mod NUM_REQ). ptr resets to NUM_REQ-1, so master 0 wins first.
- bus_addr/bus_wdata hold last values when idle; only strobes and bus_oe gate activity.
- A master dropping req before ack: transaction already in ACCESS completes; ack still pulses; master must ignore it.
- we/addr/wdata changes during ACCESS/ACK are ignored (values registered at grant).

## Timing
- Reset values: state IDLE, gnt 0, ack 0, rdata 0, bus_addr 0, bus_wdata 0, bus_oe 0, bus_rd 0, bus_wr 0, ptr NUM_REQ-1.
- Reset asserted in any state aborts immediately; strobes drop asynchronously, no ack issued.
- Latency: req high before edge k (state IDLE) -> gnt and strobe high after edge k -> ack high after edge k+1, rdata valid same cycle.
- Throughput: back-to-back transactions every 2 cycles while any other master requests.
- Strobe is high for exactly one cycle per transaction; bus_rd and bus_wr never both high; bus_oe == bus_wr.
- gnt is one-hot or zero at all times; changes only on the edge entering ACCESS or IDLE.

## Configuration
- DB_ARB_LOCK_EN defined: in ACK, if lock[owner] and req[owner] are both high, owner is not masked and wins unconditionally (burst); ptr not advanced until lock drops. Lock ignored for non-owners.
- DB_ARB_LOCK_EN undefined: lock port present but ignored; strict round-robin, no master ever gets two consecutive transactions while another requests.

## Test plan
- Single read: master 0 reads 0x1003 with slave returning 0xA5 -> bus_rd one cycle with bus_addr 0x1003, ack[0] two cycles after req, rdata 0xA5.
- Single write: master 2 writes 0x3C to 0x1007 -> bus_wr=bus_oe=1 for one cycle, bus_wdata 0x3C; read-back by master 1 returns 0x3C.
- Contention: req=4'b1111 held, each dropped at its ack -> grant order 0,1,2,3, acks spaced 2 cycles, no idle cycle between.
- Fairness: master 1 re-requests immediately after each ack while master 3 waits -> grants alternate 1,3,1,3.
- Lock (DB_ARB_LOCK_EN): master 0 locks for 3 reads while master 1 requests -> three consecutive master-0 transactions, then master 1; without macro, alternates 0,1,0.
- Reset during ACCESS: assert reset mid-write -> bus_wr/bus_oe low immediately, no ack, all outputs at reset values; post-reset first request served normally.

Source files
------------

// File: rtl/db_arbiter.sv
// Round-robin data-bus arbiter: serialises master requests into two-cycle
// ACCESS/ACK transactions. Define DB_ARB_LOCK_EN to let a locked owner burst.
module db_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  input  logic [NUM_REQ-1:0]        lock,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         bus_addr,
  output logic [DATA_W-1:0]         bus_wdata,
  output logic                      bus_oe,
  output logic                      bus_rd,
  output logic                      bus_wr,
  input  logic [DATA_W-1:0]         bus_rdata
);

  localparam int IDX_W = $clog2(NUM_REQ);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_ACK    = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic [ADDR_W-1:0]  bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]  bus_wdata_q, bus_wdata_d;
  logic               we_q, we_d;

  logic [IDX_W-1:0]   own_idx;
  logic [IDX_W-1:0]   arb_base;
  logic [NUM_REQ-1:0] arb_mask;
  logic               burst;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;

  always_comb begin
    own_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt_q[i]) own_idx = IDX_W'(i);
  end

`ifdef DB_ARB_LOCK_EN
  assign burst = (state_q == S_ACK) && lock[own_idx] && req[own_idx];
`else
  logic unused_lock;
  assign unused_lock = ^lock;
  assign burst       = 1'b0;
`endif

  // In ACK the search starts just after the current owner and skips it, so
  // the owner can only win again (without a burst) via IDLE.
  always_comb begin
    int j;
    j         = 0;
    arb_base  = (state_q == S_ACK) ? own_idx : ptr_q;
    arb_mask  = req;
    if (state_q == S_ACK) arb_mask[own_idx] = 1'b0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = int'(arb_base) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!win_found && arb_mask[IDX_W'(j)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(j);
      end
    end
    if (burst) begin
      win_found = 1'b1;
      win_idx   = own_idx;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    ack_d       = '0;
    rdata_d     = rdata_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    we_d        = we_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d     = S_ACCESS;
          gnt_d       = NUM_REQ'(1) << win_idx;
          we_d        = we[win_idx];
          bus_addr_d  = addr[win_idx*ADDR_W +: ADDR_W];
          bus_wdata_d = wdata[win_idx*DATA_W +: DATA_W];
        end
      end
      S_ACCESS: begin
        if (!we_q) rdata_d = bus_rdata;
        ack_d   = gnt_q;
        state_d = S_ACK;
      end
      S_ACK: begin
        if (!burst) ptr_d = own_idx;
        if (win_found) begin
          state_d     = S_ACCESS;
          gnt_d       = NUM_REQ'(1) << win_idx;
          we_d        = we[win_idx];
          bus_addr_d  = addr[win_idx*ADDR_W +: ADDR_W];
          bus_wdata_d = wdata[win_idx*DATA_W +: DATA_W];
        end else begin
          state_d = S_IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= IDX_W'(NUM_REQ - 1);
      gnt_q       <= '0;
      ack_q       <= '0;
      rdata_q     <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      we_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      we_q        <= we_d;
    end
  end

  // Strobes decode straight from state so reset kills them asynchronously.
  assign bus_rd    = (state_q == S_ACCESS) && !we_q;
  assign bus_wr    = (state_q == S_ACCESS) && we_q;
  assign bus_oe    = bus_wr;
  assign gnt       = gnt_q;
  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_db_arbiter.sv
// Directed bench for db_arbiter: vector table of single transactions plus
// contention, fairness, lock and reset-abort sequences against a small slave.
module tb_db_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req, we, lock, gnt, ack;
  logic [63:0] addr;
  logic [31:0] wdata;
  logic [7:0]  rdata, bus_wdata, bus_rdata;
  logic [15:0] bus_addr;
  logic        bus_oe, bus_rd, bus_wr;

  int total = 0;
  int bad   = 0;
  int order[$];
  int when_q[$];

  logic [7:0] mem [0:255];

  db_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .lock(lock), .gnt(gnt), .ack(ack), .rdata(rdata), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_oe(bus_oe), .bus_rd(bus_rd), .bus_wr(bus_wr),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  assign bus_rdata = bus_rd ? mem[bus_addr[7:0]] : 8'h00;
  always @(posedge clk) if (bus_wr && bus_oe) mem[bus_addr[7:0]] <= bus_wdata;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  m;
    logic        w;
    logic [15:0] a;
    logic [7:0]  d;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t tbl [6];

  task automatic do_txn(input logic [1:0] m, input logic w, input logic [15:0] a,
                        input logic [7:0] d, input logic [7:0] exp_rd);
    @(negedge clk);
    req = '0; req[m] = 1'b1; we[m] = w;
    addr[m*16 +: 16] = a; wdata[m*8 +: 8] = d;
    @(posedge clk); #1;
    chk("gnt",       32'(gnt),    32'(4'b0001 << m));
    chk("bus_rd",    32'(bus_rd), 32'(!w));
    chk("bus_wr",    32'(bus_wr), 32'(w));
    chk("bus_oe",    32'(bus_oe), 32'(w));
    chk("bus_addr",  32'(bus_addr), 32'(a));
    if (w) chk("bus_wdata", 32'(bus_wdata), 32'(d));
    chk("ack_early", 32'(ack), 32'(0));
    @(posedge clk); #1;
    chk("ack",       32'(ack), 32'(4'b0001 << m));
    chk("strobe_off", 32'({bus_rd, bus_wr, bus_oe}), 32'(0));
    chk("rdata",     32'(rdata), 32'(exp_rd));
    req[m] = 1'b0;
    @(posedge clk); #1;
    chk("idle_gnt",  32'(gnt), 32'(0));
    chk("idle_ack",  32'(ack), 32'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req = '0; lock = '0; we = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Each master holds req until it has seen cN acks; lock follows req for masters in lk.
  task automatic run_burst(input string tag, input int c0, input int c1, input int c2,
                           input int c3, input logic [3:0] lk);
    int cnt [4];
    int cyc;
    cnt = '{c0, c1, c2, c3};
    order.delete(); when_q.delete();
    @(negedge clk);
    we = '0;
    for (int i = 0; i < 4; i++) begin
      addr[i*16 +: 16] = 16'h1000 | 16'(i);
      req[i]  = cnt[i] > 0;
      lock[i] = lk[i] && (cnt[i] > 0);
    end
    cyc = 0;
    while ((cnt[0] + cnt[1] + cnt[2] + cnt[3]) > 0 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      chk({tag, "_onehot"}, 32'($onehot0(gnt)), 32'(1));
      chk({tag, "_rdwr"},   32'(bus_rd && bus_wr), 32'(0));
      chk({tag, "_oe"},     32'(bus_oe), 32'(bus_wr));
      for (int i = 0; i < 4; i++)
        if (ack[i]) begin
          order.push_back(i);
          when_q.push_back(cyc);
          if (cnt[i] > 0) cnt[i]--;
        end
      for (int i = 0; i < 4; i++) begin
        req[i]  = cnt[i] > 0;
        lock[i] = lk[i] && (cnt[i] > 0);
      end
    end
    if (cyc >= 200) begin
      total++; bad++;
      $display("FAIL %s timeout: got no completion want all acks", tag);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_order(input string tag, input int e0, input int e1,
                           input int e2, input int e3, input logic spacing);
    int e [4];
    e = '{e0, e1, e2, e3};
    chk({tag, "_count"}, 32'(order.size()), 32'(4));
    for (int j = 0; j < 4; j++) begin
      if (j < order.size()) chk($sformatf("%s_order%0d", tag, j), 32'(order[j]), 32'(e[j]));
      else                  chk($sformatf("%s_order%0d", tag, j), 32'hFFFF_FFFF, 32'(e[j]));
      if (spacing && j < when_q.size())
        chk($sformatf("%s_cyc%0d", tag, j), 32'(when_q[j]), 32'(2 + 2*j));
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h03] = 8'hA5;
    mem[8'h00] = 8'h11;

    tbl[0] = '{m: 2'd0, w: 1'b0, a: 16'h1003, d: 8'h00, exp_rd: 8'hA5};
    tbl[1] = '{m: 2'd2, w: 1'b1, a: 16'h1007, d: 8'h3C, exp_rd: 8'hA5};
    tbl[2] = '{m: 2'd1, w: 1'b0, a: 16'h1007, d: 8'h00, exp_rd: 8'h3C};
    tbl[3] = '{m: 2'd3, w: 1'b1, a: 16'h10FF, d: 8'h5A, exp_rd: 8'h3C};
    tbl[4] = '{m: 2'd3, w: 1'b0, a: 16'h10FF, d: 8'h00, exp_rd: 8'h5A};
    tbl[5] = '{m: 2'd0, w: 1'b0, a: 16'h0000, d: 8'h00, exp_rd: 8'h11};

    reset = 1'b1; req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
    #1;
    chk("rst_gnt",   32'(gnt), 32'(0));
    chk("rst_ack",   32'(ack), 32'(0));
    chk("rst_rdata", 32'(rdata), 32'(0));
    chk("rst_addr",  32'(bus_addr), 32'(0));
    chk("rst_wdata", 32'(bus_wdata), 32'(0));
    chk("rst_strb",  32'({bus_rd, bus_wr, bus_oe}), 32'(0));
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 6; v++)
      do_txn(tbl[v].m, tbl[v].w, tbl[v].a, tbl[v].d, tbl[v].exp_rd);

    do_reset();
    run_burst("contend", 1, 1, 1, 1, 4'b0000);
    chk_order("contend", 0, 1, 2, 3, 1'b1);

    run_burst("fair", 0, 2, 0, 2, 4'b0000);
    chk_order("fair", 1, 3, 1, 3, 1'b1);

    do_reset();
    run_burst("lock", 3, 1, 0, 0, 4'b0001);
`ifdef DB_ARB_LOCK_EN
    chk_order("lock", 0, 0, 0, 1, 1'b1);
`else
    chk_order("lock", 0, 1, 0, 0, 1'b0);
`endif

    // Abort a write in ACCESS with an asynchronous reset.
    @(negedge clk);
    req = 4'b0100; we = 4'b0100;
    addr[2*16 +: 16] = 16'h1020; wdata[2*8 +: 8] = 8'h77;
    @(posedge clk); #1;
    chk("abort_wr_pre", 32'(bus_wr), 32'(1));
    chk("abort_oe_pre", 32'(bus_oe), 32'(1));
    #2;
    reset = 1'b1;
    #1;
    chk("abort_strb",  32'({bus_rd, bus_wr, bus_oe}), 32'(0));
    chk("abort_gnt",   32'(gnt), 32'(0));
    chk("abort_ack",   32'(ack), 32'(0));
    chk("abort_addr",  32'(bus_addr), 32'(0));
    chk("abort_wdata", 32'(bus_wdata), 32'(0));
    chk("abort_rdata", 32'(rdata), 32'(0));
    req = '0; we = '0;
    @(posedge clk); #1;
    chk("abort_ack_hold", 32'(ack), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    do_txn(2'd1, 1'b0, 16'h1003, 8'h00, 8'hA5);
    do_txn(2'd0, 1'b0, 16'h1020, 8'h00, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
